// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the posted data-memory write buffer.
package mips_mem_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 32;
  localparam int WB_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR    = 2'd1,
    ST_RD    = 2'd2,
    ST_LDONE = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/data_write_buffer_fifo.sv
// In-order store FIFO with wrap-bit pointers; youngest-match search only when
// WB_FORWARD_EN is defined.
module wb_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] head_addr_o,
  output logic [DW-1:0] head_data_o
`ifdef WB_FORWARD_EN
  ,
  input  logic [AW-1:0] srch_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] hit_data_o
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  assign empty_o     = (head_q == tail_q);
  assign full_o      = ((head_q ^ tail_q) == {1'b1, {IW{1'b0}}});
  assign head_addr_o = addr_mem[head_q[IW-1:0]];
  assign head_data_o = data_mem[head_q[IW-1:0]];

  always_comb begin
    head_d = head_q + PW'(pop_i && !empty_o);
    tail_d = tail_q + PW'(push_i && !full_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      addr_mem[tail_q[IW-1:0]] <= push_addr_i;
      data_mem[tail_q[IW-1:0]] <= push_data_i;
    end
  end

`ifdef WB_FORWARD_EN
  logic [PW-1:0] count;
  logic [IW-1:0] idx;
  assign count = tail_q - head_q;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q[IW-1:0] + IW'(k);
      if ((PW'(k) < count) && (addr_mem[idx] == srch_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_mem[idx];
      end
    end
  end
`endif

endmodule

// File: rtl/data_write_buffer.sv
// Posted store buffer between the core data port and a handshaked memory.
// Optional store-to-load forwarding is enabled by defining WB_FORWARD_EN.
module data_write_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [AW-1:0] Address_DataMem,
  input  logic [DW-1:0] WriteData_DataMem,
  output logic [DW-1:0] ReadData_DataMem,
  output logic          Stall,
  output logic          Mem_Req,
  output logic          Mem_We,
  output logic [AW-1:0] Mem_Addr,
  output logic [DW-1:0] Mem_WData,
  input  logic          Mem_Ack,
  input  logic [DW-1:0] Mem_RData
);

  wb_state_e     state_q, state_d;
  logic          req_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, load_q;
  logic          full, empty, hit, is_load, rd_go, ack_ok;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  // A simultaneous store and load is taken as a store only.
  assign is_load = MemRead && !MemWrite;
  assign ack_ok  = Mem_Ack && req_q;

`ifdef WB_FORWARD_EN
  logic [DW-1:0] hit_data;
  assign rd_go = is_load && !hit;
`else
  assign hit   = 1'b0;
  assign rd_go = is_load && empty;
`endif

  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .push_i      (MemWrite),
    .push_addr_i (Address_DataMem),
    .push_data_i (WriteData_DataMem),
    .pop_i       (state_q == ST_WR && ack_ok),
    .full_o      (full),
    .empty_o     (empty),
    .head_addr_o (head_addr),
    .head_data_o (head_data)
`ifdef WB_FORWARD_EN
    ,
    .srch_addr_i (Address_DataMem),
    .hit_o       (hit),
    .hit_data_o  (hit_data)
`endif
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    ReadData_DataMem = '0;
    Stall            = (MemWrite && full) || (is_load && !hit && state_q != ST_LDONE);
    if (is_load && state_q == ST_LDONE) ReadData_DataMem = load_q;
`ifdef WB_FORWARD_EN
    else if (is_load && hit) ReadData_DataMem = hit_data;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rd_go)       state_d = ST_RD;
        else if (!empty) state_d = ST_WR;
      end
      ST_WR:    if (ack_ok) state_d = rd_go ? ST_RD : ST_IDLE;
      ST_RD:    if (ack_ok) state_d = ST_LDONE;
      ST_LDONE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // WR->RD enters with the request low so Mem_Req always gaps between transfers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && state_d == ST_WR) begin
        req_q   <= 1'b1;
        we_q    <= 1'b1;
        addr_q  <= head_addr;
        wdata_q <= head_data;
      end else if (state_q == ST_IDLE && state_d == ST_RD) begin
        req_q  <= 1'b1;
        we_q   <= 1'b0;
        addr_q <= Address_DataMem;
      end else if (state_q == ST_WR && state_d == ST_RD) begin
        req_q  <= 1'b0;
        we_q   <= 1'b0;
        addr_q <= Address_DataMem;
      end else if (state_q == ST_RD && !req_q) begin
        req_q <= 1'b1;
      end else if (ack_ok) begin
        req_q <= 1'b0;
        we_q  <= 1'b0;
      end
      if (state_q == ST_RD && ack_ok) load_q <= Mem_RData;
    end
  end

  assign Mem_Req   = req_q;
  assign Mem_We    = we_q;
  assign Mem_Addr  = addr_q;
  assign Mem_WData = wdata_q;

endmodule

// File: tb/tb_data_write_buffer.sv
// Randomized bench for data_write_buffer against an architectural memory model
// and a write-order scoreboard; follows WB_FORWARD_EN when defined.
module tb_data_write_buffer;

  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MemWrite = 1'b0, MemRead = 1'b0;
  logic [31:0] Address_DataMem = '0, WriteData_DataMem = '0;
  logic [31:0] ReadData_DataMem;
  logic        Stall, Mem_Req, Mem_We;
  logic [31:0] Mem_Addr, Mem_WData;
  logic        Mem_Ack = 1'b0;
  logic [31:0] Mem_RData = '0;

  data_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .Clock             (Clock),
    .Reset_n           (Reset_n),
    .MemWrite          (MemWrite),
    .MemRead           (MemRead),
    .Address_DataMem   (Address_DataMem),
    .WriteData_DataMem (WriteData_DataMem),
    .ReadData_DataMem  (ReadData_DataMem),
    .Stall             (Stall),
    .Mem_Req           (Mem_Req),
    .Mem_We            (Mem_We),
    .Mem_Addr          (Mem_Addr),
    .Mem_WData         (Mem_WData),
    .Mem_Ack           (Mem_Ack),
    .Mem_RData         (Mem_RData)
  );

  always #5 Clock = ~Clock;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        pend[$];
  logic [31:0] arch[logic [31:0]];
  logic [31:0] mem_dev[logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] rd_arch(input logic [31:0] a);
    if (arch.exists(a)) return arch[a];
    return init_val(a);
  endfunction
  function automatic logic [31:0] rd_dev(input logic [31:0] a);
    if (mem_dev.exists(a)) return mem_dev[a];
    return init_val(a);
  endfunction
  function automatic bit pend_has(input logic [31:0] a);
    foreach (pend[i]) if (pend[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // Memory model: acks cur_lat cycles after a request appears, unless held off.
  bit          hold = 0, rand_lat = 0;
  int          fix_lat = 3, pulse_req = 0, pulse_seen = 0;
  int          n_writes = 0, n_reads = 0;
  bit          active = 0;
  int          cnt = 0, cur_lat = 1;
  logic [31:0] cap_addr, cap_wd;
  logic        cap_we;

  always @(negedge Clock) begin
    if (!Reset_n) begin
      Mem_Ack = 1'b0;
      active  = 0;
      cnt     = 0;
    end else if (Mem_Ack) begin
      Mem_Ack = 1'b0;
      active  = 0;
      chk("req_gap", Mem_Req, 1'b0);
    end else if (pulse_req != pulse_seen) begin
      pulse_seen++;
      Mem_Ack = 1'b1;
    end else if (Mem_Req) begin
      if (!active) begin
        active   = 1;
        cnt      = 0;
        cur_lat  = rand_lat ? int'($urandom_range(1, 4)) : fix_lat;
        cap_addr = Mem_Addr;
        cap_we   = Mem_We;
        cap_wd   = Mem_WData;
        if (!Mem_We) begin
          n_reads++;
`ifdef WB_FORWARD_EN
          chk("rd_past_match", pend_has(Mem_Addr), 1'b0);
`else
          chk("rd_after_drain", pend.size(), 0);
`endif
        end
      end else begin
        chk("stable_addr", Mem_Addr, cap_addr);
        chk("stable_we_wd", {Mem_We, Mem_WData}, {cap_we, cap_wd});
      end
      if (!hold) begin
        cnt++;
        if (cnt >= cur_lat) begin
          Mem_Ack = 1'b1;
          if (Mem_We) begin
            n_writes++;
            if (pend.size() == 0) chk("wr_unexpected", 1'b1, 1'b0);
            else begin
              ent_t e;
              e = pend.pop_front();
              chk("wr_addr", Mem_Addr, e.a);
              chk("wr_data", Mem_WData, e.d);
            end
            mem_dev[Mem_Addr] = Mem_WData;
          end else begin
            Mem_RData = rd_dev(Mem_Addr);
          end
        end
      end
    end
  end

  // One core instruction; starts and ends 1 time unit after a rising edge.
  task automatic core_op(input bit we, input bit re, input logic [31:0] a,
                         input logic [31:0] d, output int stalls);
    bit exp_stall;
    bit done;
    int cyc;
    MemWrite = we; MemRead = re; Address_DataMem = a; WriteData_DataMem = d;
    stalls = 0; done = 0; cyc = 0;
    while (!done) begin
      #2;
      if (cyc == 0) begin
        if (we) exp_stall = (pend.size() >= DEPTH);
`ifdef WB_FORWARD_EN
        else if (re) exp_stall = !pend_has(a);
`else
        else if (re) exp_stall = 1'b1;
`endif
        else exp_stall = 1'b0;
        chk("stall_first", Stall, exp_stall);
      end
      if (!Stall) begin
        if (we) begin
          pend.push_back('{a, d});
          arch[a] = d;
        end else if (re) chk("load_data", ReadData_DataMem, rd_arch(a));
        else chk("idle_rdata", ReadData_DataMem, 32'h0);
        done = 1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          chk("stall_timeout", 1'b1, 1'b0);
          done = 1;
        end
      end
      cyc++;
      @(posedge Clock); #1;
    end
    MemWrite = 1'b0; MemRead = 1'b0;
    $display("op we=%0b re=%0b addr=%0h data=%0h stalls=%0d", we, re, a, d, stalls);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((pend.size() != 0 || Mem_Req) && k < 300) begin
      @(posedge Clock); #1;
      k++;
    end
    chk("drain_timeout", k < 300, 1'b1);
  endtask

  task automatic check_idle_after_reset(input string tag);
    pulse_req++;
    repeat (6) begin
      @(posedge Clock); #2;
      chk(tag, {Mem_Req, Stall}, 2'b00);
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    int st, w0, r0;
    logic [31:0] a, d;
    int r;

    repeat (3) @(posedge Clock);
    #1;
    chk("rst_req_we", {Mem_Req, Mem_We}, 2'b00);
    chk("rst_addr", Mem_Addr, 32'h0);
    chk("rst_wdata", Mem_WData, 32'h0);
    chk("rst_stall_rdata", {Stall, ReadData_DataMem}, 33'h0);
    Reset_n = 1'b1;
    @(posedge Clock); #1;

    // Single store drain
    w0 = n_writes;
    core_op(1, 0, 32'h10, 32'hDEADBEEF, st);
    chk("single_nostall", st, 0);
    wait_drain();
    chk("single_wr_cnt", n_writes - w0, 1);
    chk("single_mem", rd_dev(32'h10), 32'hDEADBEEF);

    // Fill and stall with acks held off
    w0 = n_writes;
    hold = 1;
    for (int i = 0; i < 4; i++) core_op(1, 0, 32'h100 + i, $urandom, st);
    fork
      core_op(1, 0, 32'h104, 32'h0000_0104, st);
      begin repeat (5) @(posedge Clock); hold = 0; end
    join
    chk("fill_stalled", st > 0, 1'b1);
    wait_drain();
    chk("fill_wr_cnt", n_writes - w0, 5);

    // Forwarding from the youngest entry
    hold = 1;
    core_op(1, 0, 32'h20, 32'h1, st);
    core_op(1, 0, 32'h20, 32'h2, st);
    r0 = n_reads;
    fork
      core_op(0, 1, 32'h20, 32'h0, st);
      begin repeat (4) @(posedge Clock); hold = 0; end
    join
`ifdef WB_FORWARD_EN
    chk("fwd_nostall", st, 0);
    chk("fwd_no_read", n_reads - r0, 0);
`endif
    hold = 0;
    wait_drain();

    // Load miss while stores drain
    mem_dev[32'h30] = 32'h55;
    arch[32'h30]    = 32'h55;
    w0 = n_writes;
    for (int i = 0; i < 3; i++) core_op(1, 0, 32'h40 + i, 32'hC0 + i, st);
    core_op(0, 1, 32'h30, 32'h0, st);
    wait_drain();
    chk("drain_after_miss", n_writes - w0, 3);

    // Miss latency with an empty buffer and a 3-cycle memory
    fix_lat = 3;
    core_op(0, 1, 32'h50, 32'h0, st);
    chk("miss_latency", st, 4);

    // Randomized mix over a small address window
    rand_lat = 1;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      a = 32'h200 + $urandom_range(0, 7);
      d = $urandom;
      if (r < 45)      core_op(1, 0, a, d, st);
      else if (r < 90) core_op(0, 1, a, d, st);
      else if (r < 95) core_op(1, 1, a, d, st);
      else             core_op(0, 0, a, d, st);
    end
    wait_drain();
    foreach (arch[k]) chk("final_mem", rd_dev(k), arch[k]);
    rand_lat = 0;

    // Reset during an in-flight write discards the buffer
    hold = 1;
    core_op(1, 0, 32'h300, 32'h3, st);
    core_op(1, 0, 32'h301, 32'h4, st);
    repeat (2) @(posedge Clock);
    #2;
    chk("req_before_rst", Mem_Req, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("rst_wr_abort", {Mem_Req, Mem_We, Stall}, 3'b000);
    pend.delete();
    arch = mem_dev;
    hold = 0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    check_idle_after_reset("post_rst_wr");

    // Reset during a read
    hold = 1;
    MemRead = 1'b1; Address_DataMem = 32'h310;
    repeat (3) @(posedge Clock);
    #2;
    chk("rd_issued", {Mem_Req, Mem_We}, 2'b10);
    Reset_n = 1'b0; MemRead = 1'b0;
    #1;
    chk("rst_rd_abort", {Mem_Req, Stall, ReadData_DataMem}, 34'h0);
    hold = 0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    check_idle_after_reset("post_rst_rd");

    core_op(1, 0, 32'h310, 32'h1234, st);
    core_op(0, 1, 32'h310, 32'h0, st);
    wait_drain();
    chk("post_rst_mem", rd_dev(32'h310), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
